// File: rtl/spi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_bridge_pkg
// Brief    : Shared constants, state encodings and byte-sequence helper for
//            the SPI master bridge.
// Revision : 1.0 - initial release
// ============================================================================
package spi_bridge_pkg;

    localparam logic [7:0] SPI_CMD_ADDR = 8'h01;
    localparam logic [7:0] SPI_CMD_DATA = 8'h02;

    localparam logic [1:0] REG_ADDR   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [3:0] FIRST_BYTE_IDX = 4'd0;
    localparam logic [3:0] DATA_CMD_IDX   = 4'd5;
    localparam logic [3:0] LAST_BYTE_IDX  = 4'd9;

    // Per-byte engine states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_HIGH  = 3'd3,
        ST_LOW   = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_t;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    function automatic logic [7:0] seq_byte(input logic [3:0]  idx,
                                            input logic [31:0] addr,
                                            input logic [31:0] data);
        logic [7:0] b;
        case (idx)
            4'd0:    b = SPI_CMD_ADDR;
            4'd1:    b = addr[31:24];
            4'd2:    b = addr[23:16];
            4'd3:    b = addr[15:8];
            4'd4:    b = addr[7:0];
            4'd5:    b = SPI_CMD_DATA;
            4'd6:    b = data[31:24];
            4'd7:    b = data[23:16];
            4'd8:    b = data[15:8];
            4'd9:    b = data[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_bridge_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_tx
// Brief    : Sends one byte MSB-first in SPI mode 0 inside its own CS frame,
//            followed by a CS-high gap. Back-to-back bytes chain via i_start.
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_tx
    import spi_bridge_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_done,
    output logic       o_sclk,
    output logic       o_cs,
    output logic       o_mosi
);

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

    spi_state_t r_state;
    spi_state_t w_state_next;
    logic [7:0] r_div;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_sclk;
    logic       r_cs;
    logic       r_mosi;
    logic       w_phase_end;

    assign w_phase_end = (r_div == 8'd0);

    always_comb begin
        w_state_next = r_state;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_SETUP;
            ST_SETUP: if (w_phase_end) w_state_next = ST_HIGH;
            ST_HIGH:  if (w_phase_end) w_state_next = ST_LOW;
            ST_LOW:   if (w_phase_end) w_state_next = (r_bit == 3'd7) ? ST_GAP : ST_HIGH;
            ST_GAP: begin
                if (w_phase_end) begin
                    o_done       = 1'b1;
                    w_state_next = i_start ? ST_LOAD : ST_IDLE;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // sclk/cs are decoded from the next state so they toggle exactly on phase entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div   <= 8'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_sclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            if (r_state != w_state_next) begin
                r_div <= (w_state_next == ST_GAP) ? GAP_RELOAD : DIV_RELOAD;
            end else if (r_div != 8'd0) begin
                r_div <= r_div - 8'd1;
            end
            r_sclk <= (w_state_next == ST_HIGH);
            r_cs   <= !((w_state_next == ST_SETUP) || (w_state_next == ST_HIGH) ||
                        (w_state_next == ST_LOW));
            if (r_state == ST_LOAD) begin
                r_shift <= i_byte;
                r_mosi  <= i_byte[7];
                r_bit   <= 3'd0;
            end
            if ((r_state == ST_HIGH) && (w_state_next == ST_LOW) && (r_bit != 3'd7)) begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_mosi  <= r_shift[6];
            end
            if ((r_state == ST_LOW) && (w_state_next == ST_HIGH)) begin
                r_bit <= r_bit + 3'd1;
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_cs   = r_cs;
    assign o_mosi = r_mosi;

endmodule
`default_nettype wire

// File: rtl/spi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_bridge
// Brief    : Bus-mapped SPI master issuing ADDR/DATA command frames for a
//            remote 32-bit write. Optional macro SPI_MASTER_ADDR_CACHE_EN
//            skips the address frame when the address is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_bridge
    import spi_bridge_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_wr_data,
    input  logic [3:0]  i_bus_size,
    input  logic        i_bus_read,
    input  logic        i_bus_write,
    output logic [31:0] o_bus_rd_data,
    output logic        o_busy,
    output logic        sclk,
    output logic        cs,
    output logic        mosi
);

    seq_state_t  r_seq;
    seq_state_t  w_seq_next;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_sh_addr;
    logic [31:0] r_sh_data;
    logic [31:0] r_rd_data;
    logic [3:0]  r_idx;
    logic        r_busy;
    logic        r_done;
    logic        w_wr_en;
    logic [1:0]  w_sel;
    logic        w_start_acc;
    logic        w_tx_start;
    logic        w_tx_done;
    logic [3:0]  w_first_idx;
    logic        w_unused;

    assign w_unused    = ^{i_bus_addr[31:4], i_bus_addr[1:0]};
    assign w_sel       = i_bus_addr[3:2];
    assign w_wr_en     = i_bus_write && (i_bus_size == 4'b1111);
    assign w_start_acc = w_wr_en && (w_sel == REG_CTRL) && i_bus_wr_data[0] && (r_seq == SEQ_IDLE);

`ifdef SPI_MASTER_ADDR_CACHE_EN
    logic        r_cache_valid;
    logic [31:0] r_cache_addr;

    // The remote slave retains its address buffer, so a repeat address can skip bytes 0-4
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cache_valid <= 1'b0;
            r_cache_addr  <= 32'd0;
        end else if (r_seq == SEQ_DONE) begin
            r_cache_valid <= 1'b1;
            r_cache_addr  <= r_sh_addr;
        end
    end

    assign w_first_idx = (r_cache_valid && (r_cache_addr == r_addr)) ? DATA_CMD_IDX : FIRST_BYTE_IDX;
`else
    assign w_first_idx = FIRST_BYTE_IDX;
`endif

    always_comb begin
        w_seq_next = r_seq;
        w_tx_start = 1'b0;
        case (r_seq)
            SEQ_IDLE: begin
                if (w_start_acc) begin
                    w_seq_next = SEQ_RUN;
                    w_tx_start = 1'b1;
                end
            end
            SEQ_RUN: begin
                if (w_tx_done) begin
                    if (r_idx == LAST_BYTE_IDX) w_seq_next = SEQ_DONE;
                    else                        w_tx_start = 1'b1;
                end
            end
            SEQ_DONE: w_seq_next = SEQ_IDLE;
            default:  w_seq_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seq <= SEQ_IDLE;
        end else begin
            r_seq <= w_seq_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr    <= 32'd0;
            r_data    <= 32'd0;
            r_sh_addr <= 32'd0;
            r_sh_data <= 32'd0;
            r_rd_data <= 32'd0;
            r_idx     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_wr_en && !r_busy && (w_sel == REG_ADDR)) r_addr <= i_bus_wr_data;
            if (w_wr_en && !r_busy && (w_sel == REG_DATA)) r_data <= i_bus_wr_data;
            if (w_start_acc) begin
                r_sh_addr <= r_addr;
                r_sh_data <= r_data;
                r_idx     <= w_first_idx;
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
            end else if ((r_seq == SEQ_RUN) && w_tx_start) begin
                r_idx <= r_idx + 4'd1;
            end
            if (r_seq == SEQ_DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (i_bus_read) begin
                case (w_sel)
                    REG_ADDR:   r_rd_data <= r_addr;
                    REG_DATA:   r_rd_data <= r_data;
                    REG_STATUS: r_rd_data <= {30'd0, r_done, r_busy};
                    default:    r_rd_data <= 32'd0;
                endcase
            end
        end
    end

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_byte_tx (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_tx_start),
        .i_byte  (seq_byte(r_idx, r_sh_addr, r_sh_data)),
        .o_done  (w_tx_done),
        .o_sclk  (sclk),
        .o_cs    (cs),
        .o_mosi  (mosi)
    );

    assign o_bus_rd_data = r_rd_data;
    assign o_busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_bridge
// Brief    : Self-checking bench for spi_master_bridge; honours
//            SPI_MASTER_ADDR_CACHE_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_bridge;

    localparam int CLK_DIV     = 4;
    localparam int CS_GAP      = 8;
    localparam int BYTE_CYCLES = 17 * CLK_DIV + CS_GAP + 1;
`ifdef SPI_MASTER_ADDR_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [31:0] A_ADDR   = 32'h0;
    localparam logic [31:0] A_DATA   = 32'h4;
    localparam logic [31:0] A_CTRL   = 32'h8;
    localparam logic [31:0] A_STATUS = 32'hC;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_bus_addr = '0;
    logic [31:0] i_bus_wr_data = '0;
    logic [3:0]  i_bus_size = 4'hF;
    logic        i_bus_read = 1'b0;
    logic        i_bus_write = 1'b0;
    logic [31:0] o_bus_rd_data;
    logic        o_busy;
    logic        sclk;
    logic        cs;
    logic        mosi;

    always #5 i_clk = ~i_clk;

    spi_master_bridge #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_bus_addr    (i_bus_addr),
        .i_bus_wr_data (i_bus_wr_data),
        .i_bus_size    (i_bus_size),
        .i_bus_read    (i_bus_read),
        .i_bus_write   (i_bus_write),
        .o_bus_rd_data (o_bus_rd_data),
        .o_busy        (o_busy),
        .sclk          (sclk),
        .cs            (cs),
        .mosi          (mosi)
    );

    int checks = 0;
    int errors = 0;

    // Line monitor: frames each CS-low window into a byte with its edge count and length
    logic [7:0] byte_q[$];
    int         rise_q[$];
    int         low_q[$];
    int         gap_q[$];
    logic [7:0] m_shift = '0;
    int         m_rises = 0, m_low = 0, m_high = 0, busy_cycles = 0;
    logic       m_prev_sclk = 1'b0, m_prev_cs = 1'b1;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            m_rises = 0; m_low = 0; m_high = 0;
            m_prev_sclk = 1'b0; m_prev_cs = 1'b1;
        end else begin
            if (o_busy) busy_cycles++;
            if (!cs) begin
                if (m_prev_cs) gap_q.push_back(m_high);
                m_low++;
                if (sclk && !m_prev_sclk) begin
                    m_shift = {m_shift[6:0], mosi};
                    m_rises++;
                end
            end else begin
                if (!m_prev_cs) begin
                    byte_q.push_back(m_shift);
                    rise_q.push_back(m_rises);
                    low_q.push_back(m_low);
                    m_rises = 0; m_low = 0; m_high = 0;
                end
                m_high++;
            end
            m_prev_sclk = sclk;
            m_prev_cs   = cs;
        end
    end

    // Reference state: master address cache and the remote slave's address buffer
    bit          m_valid = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] remote_addr = '0;
    logic [7:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sz);
        @(negedge i_clk);
        i_bus_addr = a; i_bus_wr_data = d; i_bus_size = sz; i_bus_write = 1'b1;
        @(negedge i_clk);
        i_bus_write = 1'b0; i_bus_size = 4'hF;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge i_clk);
        i_bus_addr = a; i_bus_read = 1'b1;
        @(negedge i_clk);
        i_bus_read = 1'b0;
        d = o_bus_rd_data;
    endtask

    task automatic run_transfer(input logic [31:0] a, input logic [31:0] d, input bit protect);
        logic [31:0] rd;
        logic [7:0]  got;
        bit          skip;
        int          writes, i;
        logic [31:0] w_addr, w_data;
        bus_write(A_ADDR, a, 4'hF);
        bus_write(A_DATA, d, 4'hF);
        skip = CACHE_EN && m_valid && (a == m_addr);
        exp_q = {};
        if (!skip) begin
            exp_q.push_back(8'h01);
            for (int k = 3; k >= 0; k--) exp_q.push_back(a[8*k +: 8]);
        end
        exp_q.push_back(8'h02);
        for (int k = 3; k >= 0; k--) exp_q.push_back(d[8*k +: 8]);
        byte_q = {}; rise_q = {}; low_q = {}; gap_q = {};
        busy_cycles = 0;
        bus_write(A_CTRL, 32'h1, 4'hF);
        check("busy_rise", {31'd0, o_busy}, 32'd1);
        if (protect) begin
            repeat (100) @(negedge i_clk);
            bus_write(A_DATA, 32'h1234_5678, 4'hF);
            bus_write(A_CTRL, 32'h1, 4'hF);
        end
        for (int n = 0; n < 3000 && o_busy; n++) @(negedge i_clk);
        check("busy_timeout", {31'd0, o_busy}, 32'd0);
        check("busy_cycles", busy_cycles, exp_q.size() * BYTE_CYCLES + 1);
        check("byte_count", byte_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < byte_q.size()) ? byte_q[k] : 8'hxx;
            check($sformatf("byte%0d", k), {24'd0, got}, {24'd0, exp_q[k]});
            if (k < byte_q.size()) begin
                check($sformatf("rises%0d", k), rise_q[k], 8);
                check($sformatf("cs_low%0d", k), low_q[k], 17 * CLK_DIV);
            end
        end
        for (int k = 1; k < gap_q.size(); k++)
            check($sformatf("cs_gap%0d", k), {31'd0, gap_q[k] >= CS_GAP}, 32'd1);
        repeat (5) @(negedge i_clk);
        check("busy_stays_low", {31'd0, o_busy}, 32'd0);
        bus_read(A_STATUS, rd);
        check("status_done", rd, 32'h2);
        bus_read(A_DATA, rd);
        check("data_reg", rd, d);
        // Remote slave view: 0x01 loads the address buffer, 0x02 + 4 bytes is one bus write
        writes = 0; w_addr = '0; w_data = '0; i = 0;
        while (i + 4 < byte_q.size()) begin
            if (byte_q[i] == 8'h01) begin
                remote_addr = {byte_q[i+1], byte_q[i+2], byte_q[i+3], byte_q[i+4]};
                i += 5;
            end else if (byte_q[i] == 8'h02) begin
                w_addr = remote_addr;
                w_data = {byte_q[i+1], byte_q[i+2], byte_q[i+3], byte_q[i+4]};
                writes++;
                i += 5;
            end else begin
                i++;
            end
        end
        check("remote_writes", writes, 1);
        check("remote_addr", w_addr, a);
        check("remote_data", w_data, d);
        m_valid = 1'b1;
        m_addr  = a;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] ra, rdat, prev_a;

        repeat (3) @(negedge i_clk);
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_rd_data", o_bus_rd_data, 32'd0);
        i_rst_n = 1'b1;
        bus_read(A_STATUS, rd);
        check("rst_status", rd, 32'd0);
        bus_read(A_ADDR, rd);
        check("rst_addr_reg", rd, 32'd0);

        bus_write(A_ADDR, 32'h1000_0040, 4'hF);
        bus_write(A_DATA, 32'hDEAD_BEEF, 4'hF);
        bus_write(A_ADDR, 32'hFFFF_FFFF, 4'b0011);
        bus_read(A_ADDR, rd);
        check("addr_partial_ignored", rd, 32'h1000_0040);
        bus_read(A_DATA, rd);
        check("data_readback", rd, 32'hDEAD_BEEF);
        bus_read(A_CTRL, rd);
        check("ctrl_reads_zero", rd, 32'd0);

        run_transfer(32'h1000_0040, 32'hDEAD_BEEF, 1'b1);

        @(negedge i_clk);
        i_bus_addr = A_STATUS; i_bus_wr_data = 32'h0; i_bus_read = 1'b1; i_bus_write = 1'b1;
        @(negedge i_clk);
        i_bus_read = 1'b0; i_bus_write = 1'b0;
        check("status_rd_wr_same_cycle", o_bus_rd_data, 32'h2);

        bus_write(A_ADDR, 32'h2000_0080, 4'hF);
        bus_write(A_DATA, 32'hCAFE_F00D, 4'hF);
        byte_q = {};
        bus_write(A_CTRL, 32'h1, 4'hF);
        for (int n = 0; n < 2000 && !(byte_q.size() >= 3 && !cs); n++) @(negedge i_clk);
        check("reach_byte3", {31'd0, (byte_q.size() >= 3 && !cs)}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("abort_cs", {31'd0, cs}, 32'd1);
        check("abort_sclk", {31'd0, sclk}, 32'd0);
        check("abort_mosi", {31'd0, mosi}, 32'd0);
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        m_valid = 1'b0;
        bus_read(A_STATUS, rd);
        check("abort_status", rd, 32'd0);
        run_transfer(32'h2000_0080, 32'hCAFE_F00D, 1'b0);

        run_transfer(32'h1000_0040, 32'h0BAD_CAFE, 1'b0);
        run_transfer(32'h1000_0040, 32'h1357_9BDF, 1'b0);
        run_transfer(32'h1000_0044, 32'h2468_ACE0, 1'b0);

        prev_a = 32'h1000_0044;
        for (int t = 0; t < 4; t++) begin
            ra   = (t == 2) ? prev_a : $urandom;
            rdat = $urandom;
            run_transfer(ra, rdat, 1'b0);
            prev_a = ra;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
